// File: rtl/forwarding_control_unit.sv
// ---------------------------------------------------------------------------
// forwarding_control_unit
//
// Drives the EX-stage operand-mux selectors of a 5-stage MIPS pipeline and
// raises the load-use stall. It keeps its own shadow copy of the destination
// information of the instructions in EX, MEM and WB, so the datapath only has
// to present decode-stage (ID) fields.
//
// Selector encoding: 00 = register file, 01 = MEM/WB data, 10 = EX/MEM result.
//
// Ports
//   clk          pipeline clock, rising edge
//   reset        asynchronous, active-low; clears all shadow state
//   ID_Rs/ID_Rt  source register fields of the instruction in ID
//   ID_RsUsed/ID_RtUsed  instruction in ID actually reads rs / rt
//   ID_WriteReg  destination register of the instruction in ID
//   ID_RegWrite  instruction in ID writes the register file
//   ID_MemRead   instruction in ID is a load
//   Flush        instruction in ID is squashed
//   ForwardA/B   selectors for EX operand A / B muxes
//   Stall        hold PC and IF/ID, bubble ID/EX
// ---------------------------------------------------------------------------
module forwarding_control_unit #(
   parameter int NRegBits = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRegBits-1:0] ID_Rs,
   input  logic [NRegBits-1:0] ID_Rt,
   input  logic                ID_RsUsed,
   input  logic                ID_RtUsed,
   input  logic [NRegBits-1:0] ID_WriteReg,
   input  logic                ID_RegWrite,
   input  logic                ID_MemRead,
   input  logic                Flush,
   output logic [1:0]          ForwardA,
   output logic [1:0]          ForwardB,
   output logic                Stall
);

   // Destination info carried by MEM and WB. MemRead only matters while the
   // load sits in EX (that is where the stall is decided), so it is kept
   // beside the EX entry and not copied further down.
   typedef struct packed {
      logic [NRegBits-1:0] write_reg;
      logic                reg_write;
   } dst_t;

   typedef struct packed {
      dst_t                dst;
      logic                mem_read;
      logic [NRegBits-1:0] rs;
      logic [NRegBits-1:0] rt;
      logic                rs_used;
      logic                rt_used;
   } ex_t;

   ex_t  ex_q,  ex_d;
   dst_t mem_q, mem_d;
   dst_t wb_q,  wb_d;

   // Register 0 is hard-wired, so writing it never produces a forwardable value.
   function automatic logic valid_writer(input dst_t d);
      return d.reg_write && (d.write_reg != '0);
   endfunction

   // Nearest producer wins: MEM holds a newer value than WB.
   function automatic logic [1:0] fwd_sel(input logic used,
                                          input logic [NRegBits-1:0] src,
                                          input dst_t mem,
                                          input dst_t wb);
      if (used && valid_writer(mem) && (mem.write_reg == src))
         return 2'b10;
      else if (used && valid_writer(wb) && (wb.write_reg == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   // Load-use hazard: load in EX whose result the ID instruction needs next cycle.
   always_comb begin
      Stall = ex_q.mem_read && valid_writer(ex_q.dst) &&
              ((ID_RsUsed && (ID_Rs == ex_q.dst.write_reg)) ||
               (ID_RtUsed && (ID_Rt == ex_q.dst.write_reg)));
   end

   always_comb begin
      ForwardA = fwd_sel(ex_q.rs_used, ex_q.rs, mem_q, wb_q);
      ForwardB = fwd_sel(ex_q.rt_used, ex_q.rt, mem_q, wb_q);
   end

   // Next shadow state: stall or flush inserts an all-zero bubble into EX.
   always_comb begin
      ex_d  = '0;
      mem_d = ex_q.dst;
      wb_d  = mem_q;
      if (!(Stall || Flush)) begin
         ex_d.dst.write_reg = ID_WriteReg;
         ex_d.dst.reg_write = ID_RegWrite;
         ex_d.mem_read      = ID_MemRead;
         ex_d.rs            = ID_Rs;
         ex_d.rt            = ID_Rt;
         ex_d.rs_used       = ID_RsUsed;
         ex_d.rt_used       = ID_RtUsed;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

endmodule

// File: tb/tb_forwarding_control_unit.sv
// ---------------------------------------------------------------------------
// Testbench for forwarding_control_unit: hand-written vector table for the
// directed scenarios, async-reset sequences, then random instruction streams
// checked against a history-based reference model.
// ---------------------------------------------------------------------------
module tb_forwarding_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, id_wr;
   logic       id_rsu, id_rtu, id_rw, id_mr, flush;
   logic [1:0] fwd_a, fwd_b;
   logic       stall;

   int n_tests = 0;
   int n_fail  = 0;

   forwarding_control_unit #(.NRegBits(5)) dut (
      .clk(clk), .reset(reset),
      .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_RsUsed(id_rsu), .ID_RtUsed(id_rtu),
      .ID_WriteReg(id_wr), .ID_RegWrite(id_rw), .ID_MemRead(id_mr),
      .Flush(flush),
      .ForwardA(fwd_a), .ForwardB(fwd_b), .Stall(stall)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   // The model remembers the last three instructions that entered EX
   // (hist[0] = EX, hist[1] = one older = MEM, hist[2] = two older = WB)
   // and searches backwards for the most recent producer.
   typedef struct {
      logic [4:0] rs, rt, wr;
      logic       rsu, rtu, rw, mr;
   } ins_t;

   ins_t hist [3];

   function automatic logic writes(input ins_t e);
      return e.rw && (e.wr != 5'd0);
   endfunction

   function automatic logic [1:0] m_fwd(input logic used, input logic [4:0] r);
      if (!used) return 2'b00;
      for (int d = 1; d <= 2; d++)
         if (writes(hist[d]) && hist[d].wr == r)
            return (d == 1) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   function automatic logic m_stall();
      if (!(hist[0].mr && writes(hist[0]))) return 1'b0;
      return (id_rsu && id_rs == hist[0].wr) || (id_rtu && id_rt == hist[0].wr);
   endfunction

   function automatic ins_t cur_ins();
      ins_t c;
      c.rs = id_rs; c.rt = id_rt; c.wr = id_wr;
      c.rsu = id_rsu; c.rtu = id_rtu; c.rw = id_rw; c.mr = id_mr;
      return c;
   endfunction

   function automatic ins_t bubble();
      ins_t b;
      b.rs = '0; b.rt = '0; b.wr = '0;
      b.rsu = 0; b.rtu = 0; b.rw = 0; b.mr = 0;
      return b;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++) hist[k] <= bubble();
      end else begin
         hist[2] <= hist[1];
         hist[1] <= hist[0];
         hist[0] <= (m_stall() || flush) ? bubble() : cur_ins();
      end
   end

   // -------------------------------------------------------------- helpers
   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu,
                        input logic [4:0] wr, input logic rw, input logic mr,
                        input logic fl);
      id_rs = rs; id_rt = rt; id_rsu = rsu; id_rtu = rtu;
      id_wr = wr; id_rw = rw; id_mr = mr; flush = fl;
   endtask

   task automatic drive_rand();
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
   endtask

   // --------------------------------------------------------------- vectors
   // One record per cycle: ID inputs applied, outputs expected in that cycle.
   typedef struct {
      string      name;
      logic [4:0] rs, rt;
      logic       rsu, rtu;
      logic [4:0] wr;
      logic       rw, mr, fl;
      logic [1:0] fa, fb;
      logic       st;
   } vec_t;

   vec_t vecs[$];

   function automatic void v(input string nm,
                             input int rs, input int rt, input bit rsu, input bit rtu,
                             input int wr, input bit rw, input bit mr, input bit fl,
                             input int fa, input int fb, input bit st);
      vec_t x;
      x.name = nm; x.rs = 5'(rs); x.rt = 5'(rt); x.rsu = rsu; x.rtu = rtu;
      x.wr = 5'(wr); x.rw = rw; x.mr = mr; x.fl = fl;
      x.fa = 2'(fa); x.fb = 2'(fb); x.st = st;
      vecs.push_back(x);
   endfunction

   initial begin
      //        name          rs  rt rsu rtu wr  rw mr fl  fa   fb  st
      v("add8",           1,  2, 1, 1,  8, 1, 0, 0, 0, 0, 0);
      v("sub_rs8",        8,  3, 1, 1,  4, 1, 0, 0, 0, 0, 0);
      v("d1_fwd",         0,  0, 0, 0,  0, 0, 0, 0, 2, 0, 0);
      v("add9a",          1,  2, 1, 1,  9, 1, 0, 0, 0, 0, 0);
      v("add9b",          1,  2, 1, 1,  9, 1, 0, 0, 0, 0, 0);
      v("sub99",          9,  9, 1, 1,  5, 1, 0, 0, 0, 0, 0);
      v("prio_mem",       0,  0, 0, 0,  0, 0, 0, 0, 2, 2, 0);
      v("add9c",          1,  2, 1, 1,  9, 1, 0, 0, 0, 0, 0);
      v("or6",            1,  2, 1, 1,  6, 1, 0, 0, 0, 0, 0);
      v("sub99_d2",       9,  9, 1, 1,  5, 1, 0, 0, 0, 0, 0);
      v("d2_fwd",         0,  0, 0, 0,  0, 0, 0, 0, 1, 1, 0);
      v("lw10",           1,  0, 1, 0, 10, 1, 1, 0, 0, 0, 0);
      v("lu_stall",       3, 10, 1, 1,  7, 1, 0, 0, 0, 0, 1);
      v("lu_bubble",      3, 10, 1, 1,  7, 1, 0, 0, 0, 0, 0);
      v("lu_fwd01",       0,  0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
      v("addi0",          1,  0, 1, 0,  0, 1, 0, 0, 0, 0, 0);
      v("use0_a",         0,  0, 1, 1,  7, 1, 0, 0, 0, 0, 0);
      v("lw0",            2,  0, 1, 0,  0, 1, 1, 0, 0, 0, 0);
      v("use0_b",         0,  0, 1, 1,  7, 1, 0, 0, 0, 0, 0);
      v("zero_nofwd",     0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      v("lw11",           1,  0, 1, 0, 11, 1, 1, 0, 0, 0, 0);
      v("lui_unused",    11, 11, 0, 0, 13, 1, 0, 0, 0, 0, 0);
      v("unused_nofwd",   0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      v("add12_flush",    1,  2, 1, 1, 12, 1, 0, 1, 0, 0, 0);
      v("nop_f1",         0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      v("use12",         12, 12, 1, 1,  3, 1, 0, 0, 0, 0, 0);
      v("flush_nofwd",    0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      v("lw14",           1,  0, 1, 0, 14, 1, 1, 0, 0, 0, 0);
      v("stall_flush",   14,  0, 1, 0,  2, 1, 0, 1, 0, 0, 1);
      v("sf_bubble",     14,  0, 1, 0,  2, 1, 0, 0, 0, 0, 0);
   end

   // ------------------------------------------------------------------ main
   initial begin
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // Held reset: outputs stay 00/0 whatever ID presents, across edges.
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1 drive_rand();
         @(negedge clk);
         check("rst_fa", fwd_a, 0);
         check("rst_fb", fwd_b, 0);
         check("rst_stall", stall, 0);
      end

      // Release with the first table instruction already on the ID inputs.
      @(posedge clk); #1;
      reset = 1'b1;
      foreach (vecs[i]) begin
         drive(vecs[i].rs, vecs[i].rt, vecs[i].rsu, vecs[i].rtu,
               vecs[i].wr, vecs[i].rw, vecs[i].mr, vecs[i].fl);
         @(negedge clk);
         check({vecs[i].name, "_fa"}, fwd_a, vecs[i].fa);
         check({vecs[i].name, "_fb"}, fwd_b, vecs[i].fb);
         check({vecs[i].name, "_st"}, stall, vecs[i].st);
         @(posedge clk); #1;
      end

      // Reset asserted while a distance-1 forward is active: drops at once.
      drive(1, 2, 1, 1, 8, 1, 0, 0);
      @(posedge clk); #1 drive(8, 8, 1, 1, 4, 1, 0, 0);
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("pre_rst_fa", fwd_a, 2);
      check("pre_rst_fb", fwd_b, 2);
      #1 reset = 1'b0;
      #1;
      check("async_rst_fa", fwd_a, 0);
      check("async_rst_fb", fwd_b, 0);
      #1 reset = 1'b1;

      // Load in EX then asynchronous reset: stall must vanish immediately.
      @(posedge clk); #1 drive(1, 0, 1, 0, 10, 1, 1, 0);
      @(posedge clk); #1 drive(10, 0, 1, 0, 3, 1, 0, 0);
      #1;
      check("pre_rst_stall", stall, 1);
      reset = 1'b0;
      #1;
      check("async_rst_stall", stall, 0);
      #1 reset = 1'b1;

      // Random instruction streams against the model.
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1 drive_rand();
         @(negedge clk);
         check("rnd_fa", fwd_a, m_fwd(hist[0].rsu, hist[0].rs));
         check("rnd_fb", fwd_b, m_fwd(hist[0].rtu, hist[0].rt));
         check("rnd_st", stall, m_stall());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit reached");
      $fatal(1, "timeout");
   end

endmodule
